// File: rtl/warp_lsu.sv
// rtl/warp_lsu.sv - per-warp load/store unit serializing thread accesses onto one memory port
//
// Purpose:
//   Walks the enabled threads of a warp in ascending order. For each thread it
//   issues one load or store on the shared data-memory port and waits for the
//   valid/ready handshake. Load data is captured into that thread's lsu_out.
//   When every enabled thread has been serviced, lsu_done is raised until the
//   scheduler reaches WARP_UPDATE.
//
// Ports:
//   clk, reset (async, active-high), enable (low freezes everything)
//   thread_enable, warp_state, decoded_mem_read_enable, decoded_mem_write_enable,
//   decoded_immediate, rs1[], rs2[]                       - warp-side inputs
//   mem_read_valid/address/ready/data                     - load port
//   mem_write_valid/address/data/ready                    - store port
//   lsu_out[], lsu_done                                   - per-thread results, completion
//
// Build option:
//   LSU_COALESCE_EN - a load whose next thread hits the same address as the last
//                     accepted read reuses that data without a memory request.

`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

package warp_lsu_pkg;
  typedef enum logic [2:0] {
    WARP_IDLE,
    WARP_FETCH,
    WARP_DECODE,
    WARP_REQUEST,
    WARP_WAIT,
    WARP_EXECUTE,
    WARP_UPDATE,
    WARP_DONE
  } warp_state_t;

  typedef logic [`DATA_WIDTH-1:0] data_t;
endpackage

module warp_lsu
  import warp_lsu_pkg::*;
#(
  parameter int THREADS_PER_WARP = 16,
  parameter int DATA_WIDTH       = `DATA_WIDTH,
  parameter int ADDR_WIDTH       = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [THREADS_PER_WARP-1:0] thread_enable,
  input  warp_state_t                 warp_state,
  input  logic                        decoded_mem_read_enable,
  input  logic                        decoded_mem_write_enable,
  input  logic [DATA_WIDTH-1:0]       decoded_immediate,
  input  logic [DATA_WIDTH-1:0]       rs1 [THREADS_PER_WARP],
  input  logic [DATA_WIDTH-1:0]       rs2 [THREADS_PER_WARP],
  output logic                        mem_read_valid,
  output logic [ADDR_WIDTH-1:0]       mem_read_address,
  input  logic                        mem_read_ready,
  input  logic [DATA_WIDTH-1:0]       mem_read_data,
  output logic                        mem_write_valid,
  output logic [ADDR_WIDTH-1:0]       mem_write_address,
  output logic [DATA_WIDTH-1:0]       mem_write_data,
  input  logic                        mem_write_ready,
  output logic [DATA_WIDTH-1:0]       lsu_out [THREADS_PER_WARP],
  output logic                        lsu_done
);

  localparam int PW = (THREADS_PER_WARP > 1) ? $clog2(THREADS_PER_WARP) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} lsu_state_t;

  lsu_state_t                  state_q, state_d;
  logic [THREADS_PER_WARP-1:0] mask_q;
  logic                        is_load_q;
  logic [PW-1:0]               ptr_q;

  // Returns {found, index} of the lowest set mask bit above 'from'
  // (or at/above 'from' when inclusive).
  function automatic logic [PW:0] find_thread(input logic [THREADS_PER_WARP-1:0] mask,
                                              input logic [PW-1:0]               from,
                                              input logic                        inclusive);
    logic [PW:0] r;
    r = '0;
    for (int j = THREADS_PER_WARP - 1; j >= 0; j--) begin
      if (mask[j] && ((j > int'(from)) || (inclusive && (j == int'(from)))))
        r = {1'b1, PW'(j)};
    end
    return r;
  endfunction

  logic                  start;
  logic                  first_found, nxt_found;
  logic [PW-1:0]         first_idx, nxt_idx;
  logic [DATA_WIDTH-1:0] first_sum, nxt_sum;
  logic [ADDR_WIDTH-1:0] first_addr, nxt_addr;
  logic                  accept;
  logic                  coalesce_next;
  logic                  coalesce_cycle;
  logic                  step;

  assign start = enable && (state_q == S_IDLE) && (warp_state == WARP_WAIT) &&
                 (decoded_mem_read_enable || decoded_mem_write_enable);

  assign {first_found, first_idx} = find_thread(thread_enable, '0, 1'b1);
  assign {nxt_found, nxt_idx}     = find_thread(mask_q, ptr_q, 1'b0);

  // Address arithmetic wraps at the data width, then truncates to the port.
  assign first_sum  = rs1[first_idx] + decoded_immediate;
  assign nxt_sum    = rs1[nxt_idx] + decoded_immediate;
  assign first_addr = ADDR_WIDTH'(first_sum);
  assign nxt_addr   = ADDR_WIDTH'(nxt_sum);

  assign accept = is_load_q ? (mem_read_valid && mem_read_ready)
                            : (mem_write_valid && mem_write_ready);

`ifdef LSU_COALESCE_EN
  logic [DATA_WIDTH-1:0] last_data_q;
  // mem_read_address still holds the last accepted read address.
  assign coalesce_next  = is_load_q && (nxt_addr == mem_read_address);
  // In ISSUE a load with valid low is a reuse cycle.
  assign coalesce_cycle = is_load_q && !mem_read_valid;
`else
  assign coalesce_next  = 1'b0;
  assign coalesce_cycle = 1'b0;
`endif

  // One thread is retired this cycle.
  assign step = (state_q == S_ISSUE) && (accept || coalesce_cycle);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       state_q <= S_IDLE;
    else if (enable) state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = first_found ? S_ISSUE : S_DONE;
      S_ISSUE: if (step && !nxt_found) state_d = S_DONE;
      S_DONE:  if (warp_state == WARP_UPDATE) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_q            <= '0;
      is_load_q         <= 1'b0;
      ptr_q             <= '0;
      mem_read_valid    <= 1'b0;
      mem_read_address  <= '0;
      mem_write_valid   <= 1'b0;
      mem_write_address <= '0;
      mem_write_data    <= '0;
      lsu_done          <= 1'b0;
      for (int i = 0; i < THREADS_PER_WARP; i++) lsu_out[i] <= '0;
`ifdef LSU_COALESCE_EN
      last_data_q       <= '0;
`endif
    end else if (enable) begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            mask_q    <= thread_enable;
            is_load_q <= decoded_mem_read_enable;  // load wins if both are set
            ptr_q     <= first_idx;
            lsu_done  <= !first_found;
            if (first_found) begin
              if (decoded_mem_read_enable) begin
                mem_read_valid   <= 1'b1;
                mem_read_address <= first_addr;
              end else begin
                mem_write_valid   <= 1'b1;
                mem_write_address <= first_addr;
                mem_write_data    <= rs2[first_idx];
              end
            end
          end
        end
        S_ISSUE: begin
          if (step) begin
            if (is_load_q) begin
`ifdef LSU_COALESCE_EN
              lsu_out[ptr_q] <= mem_read_valid ? mem_read_data : last_data_q;
              if (mem_read_valid) last_data_q <= mem_read_data;
`else
              lsu_out[ptr_q] <= mem_read_data;
`endif
            end
            if (nxt_found) begin
              ptr_q <= nxt_idx;
              if (is_load_q) begin
                mem_read_valid   <= !coalesce_next;
                mem_read_address <= nxt_addr;
              end else begin
                mem_write_address <= nxt_addr;
                mem_write_data    <= rs2[nxt_idx];
              end
            end else begin
              mem_read_valid  <= 1'b0;
              mem_write_valid <= 1'b0;
              lsu_done        <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (warp_state == WARP_UPDATE) lsu_done <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_warp_lsu.sv
// tb/tb_warp_lsu.sv - scoreboard testbench for warp_lsu
module tb_warp_lsu;
  import warp_lsu_pkg::*;

  localparam int T = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic [T-1:0]     thread_enable;
  warp_state_t      warp_state;
  logic             rd_en, wr_en;
  logic [7:0]       imm;
  logic [7:0]       rs1 [T];
  logic [7:0]       rs2 [T];
  logic             mem_read_valid;
  logic [7:0]       mem_read_address;
  logic             mem_read_ready;
  logic [7:0]       mem_read_data;
  logic             mem_write_valid;
  logic [7:0]       mem_write_address;
  logic [7:0]       mem_write_data;
  logic             mem_write_ready;
  logic [7:0]       lsu_out [T];
  logic             lsu_done;

  typedef struct packed {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
  } req_t;

  typedef struct packed {
    logic [T-1:0][7:0] outs;
    logic              chk;
    logic [31:0]       cyc;
  } done_t;

  req_t       exp_q [$];
  done_t      done_q [$];
  logic [7:0] exp_lsu [T];
  int         tests = 0;
  int         failed = 0;
  int         cyc = 0;
  logic       rdy;
  int         rdy_delay;
  int         rdy_cnt;
  logic       done_prev;
  req_t       mon_got;
  done_t      mon_d;

  warp_lsu #(
    .THREADS_PER_WARP(T),
    .DATA_WIDTH(8),
    .ADDR_WIDTH(8)
  ) dut (
    .clk(clk),
    .reset(rst),
    .enable(enable),
    .thread_enable(thread_enable),
    .warp_state(warp_state),
    .decoded_mem_read_enable(rd_en),
    .decoded_mem_write_enable(wr_en),
    .decoded_immediate(imm),
    .rs1(rs1),
    .rs2(rs2),
    .mem_read_valid(mem_read_valid),
    .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready),
    .mem_read_data(mem_read_data),
    .mem_write_valid(mem_write_valid),
    .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data),
    .mem_write_ready(mem_write_ready),
    .lsu_out(lsu_out),
    .lsu_done(lsu_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Memory contents: memory[a] = a*3
  assign mem_read_data   = 8'(mem_read_address * 8'd3);
  assign mem_read_ready  = rdy;
  assign mem_write_ready = rdy;

  // Ready policy: tied high when rdy_delay==0, else rdy_delay stall cycles per request.
  always @(negedge clk) begin
    if (rdy_delay == 0) begin
      rdy = 1'b1;
    end else if (mem_read_valid || mem_write_valid) begin
      if (rdy_cnt == rdy_delay) begin
        rdy = 1'b1;
        rdy_cnt = 0;
      end else begin
        rdy = 1'b0;
        rdy_cnt++;
      end
    end else begin
      rdy = 1'b0;
      rdy_cnt = 0;
    end
  end

  // Monitor: compares every presented request with the queue head, pops on handshake,
  // and checks results when lsu_done rises.
  always begin
    @(negedge clk);
    #1;
    if (rst) begin
      done_prev = 1'b0;
    end else begin
      if (mem_read_valid || mem_write_valid) begin
        tests++;
        mon_got.wr   = mem_write_valid;
        mon_got.addr = mem_write_valid ? mem_write_address : mem_read_address;
        mon_got.data = mem_write_valid ? mem_write_data : 8'h00;
        if (exp_q.size() == 0) begin
          failed++;
          $display("FAIL req_unexpected got=%h exp=none", mon_got);
        end else begin
          if (mon_got !== exp_q[0]) begin
            failed++;
            $display("FAIL req got=%h exp=%h", mon_got, exp_q[0]);
          end
          if (enable && (mem_write_valid ? mem_write_ready : mem_read_ready))
            void'(exp_q.pop_front());
        end
      end
      if (lsu_done && !done_prev) begin
        if (done_q.size() == 0) begin
          tests++;
          failed++;
          $display("FAIL done_unexpected got=1 exp=0");
        end else begin
          mon_d = done_q.pop_front();
          for (int i = 0; i < T; i++) begin
            tests++;
            if (lsu_out[i] !== mon_d.outs[i]) begin
              failed++;
              $display("FAIL lsu_out[%0d] got=%h exp=%h", i, lsu_out[i], mon_d.outs[i]);
            end
          end
          if (mon_d.chk) begin
            tests++;
            if (cyc != int'(mon_d.cyc)) begin
              failed++;
              $display("FAIL done_cycle got=%0d exp=%0d", cyc, mon_d.cyc);
            end
          end
          tests++;
          if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL requests_pending got=%0d exp=0", exp_q.size());
          end
        end
      end
      done_prev = lsu_done;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic push_req(input logic wr, input logic [7:0] a, input logic [7:0] d);
    req_t r;
    r.wr = wr;
    r.addr = a;
    r.data = d;
    exp_q.push_back(r);
  endtask

  // lat: cycles from the WAIT-driving negedge to lsu_done visible; -1 skips the check.
  task automatic start_op(input logic rd, input logic wr, input logic [T-1:0] mask,
                          input logic [7:0] im, input int lat);
    done_t d;
    @(negedge clk);
    rd_en = rd;
    wr_en = wr;
    thread_enable = mask;
    imm = im;
    warp_state = WARP_WAIT;
    for (int i = 0; i < T; i++) d.outs[i] = exp_lsu[i];
    d.chk = (lat >= 0);
    d.cyc = 32'(cyc + lat);
    done_q.push_back(d);
    @(negedge clk);
    warp_state = WARP_EXECUTE;
  endtask

  task automatic finish_op();
    int n;
    n = 0;
    while (!lsu_done && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!lsu_done) begin
      tests++;
      failed++;
      $display("FAIL done_timeout got=0 exp=1");
    end
    warp_state = WARP_UPDATE;
    @(negedge clk);
    check("done_clear", {31'd0, lsu_done}, 32'd0);
    warp_state = WARP_IDLE;
  endtask

  initial begin
    rst = 1'b1;
    enable = 1'b1;
    thread_enable = '0;
    warp_state = WARP_IDLE;
    rd_en = 1'b0;
    wr_en = 1'b0;
    imm = 8'h00;
    rdy_delay = 0;
    rdy_cnt = 0;
    rdy = 1'b0;
    done_prev = 1'b0;
    for (int i = 0; i < T; i++) begin
      rs1[i] = 8'h00;
      rs2[i] = 8'h00;
      exp_lsu[i] = 8'h00;
    end

    repeat (3) @(negedge clk);
    check("rst_read_valid", {31'd0, mem_read_valid}, 32'd0);
    check("rst_write_valid", {31'd0, mem_write_valid}, 32'd0);
    check("rst_done", {31'd0, lsu_done}, 32'd0);
    check("rst_read_addr", {24'd0, mem_read_address}, 32'd0);
    check("rst_write_addr", {24'd0, mem_write_address}, 32'd0);
    check("rst_write_data", {24'd0, mem_write_data}, 32'd0);
    for (int i = 0; i < T; i++) check("rst_lsu_out", {24'd0, lsu_out[i]}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Full-mask load, ready tied high
    for (int i = 0; i < T; i++) begin
      rs1[i] = 8'(i);
      push_req(1'b0, 8'(8'h10 + i), 8'h00);
      exp_lsu[i] = 8'((8'h10 + i) * 3);
    end
    start_op(1'b1, 1'b0, 16'hFFFF, 8'h10, 17);
    finish_op();

    // Sparse store with 3-cycle ready stall per request
    for (int i = 0; i < T; i++) begin
      rs1[i] = 8'(8'h70 + i);
      rs2[i] = 8'h55;
    end
    rs1[0] = 8'h20; rs2[0] = 8'hAA;
    rs1[2] = 8'h22; rs2[2] = 8'hBB;
    push_req(1'b1, 8'h20, 8'hAA);
    push_req(1'b1, 8'h22, 8'hBB);
    rdy_delay = 3;
    start_op(1'b0, 1'b1, 16'h0005, 8'h00, 9);
    finish_op();
    rdy_delay = 0;

    // Empty mask: no traffic, done one cycle after start
    start_op(1'b1, 1'b0, 16'h0000, 8'h00, 1);
    finish_op();

    // Load and store both set: load wins; threads 0 and 15; address wraps
    rs1[0] = 8'h25;
    rs1[15] = 8'h26;
    push_req(1'b0, 8'h15, 8'h00);
    push_req(1'b0, 8'h16, 8'h00);
    exp_lsu[0] = 8'h3F;
    exp_lsu[15] = 8'h42;
    start_op(1'b1, 1'b1, 16'h8001, 8'hF0, 3);
    finish_op();

    // Enable held low for 4 cycles mid-ISSUE
    for (int i = 0; i < T; i++) rs1[i] = 8'(i);
    push_req(1'b0, 8'h10, 8'h00);
    push_req(1'b0, 8'h11, 8'h00);
    exp_lsu[0] = 8'h30;
    exp_lsu[1] = 8'h33;
    start_op(1'b1, 1'b0, 16'h0003, 8'h10, -1);
    enable = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("freeze_valid", {31'd0, mem_read_valid}, 32'd1);
      check("freeze_addr", {24'd0, mem_read_address}, 32'h10);
    end
    enable = 1'b1;
    finish_op();

    // All threads at one address
    for (int i = 0; i < T; i++) begin
      rs1[i] = 8'h40;
      exp_lsu[i] = 8'hC0;
`ifndef LSU_COALESCE_EN
      push_req(1'b0, 8'h40, 8'h00);
`endif
    end
`ifdef LSU_COALESCE_EN
    push_req(1'b0, 8'h40, 8'h00);
`endif
    start_op(1'b1, 1'b0, 16'hFFFF, 8'h00, 17);
    finish_op();

    // Reset while thread 5 is being issued
    for (int i = 0; i < T; i++) begin
      rs1[i] = 8'(i);
      push_req(1'b0, 8'(8'h10 + i), 8'h00);
    end
    start_op(1'b1, 1'b0, 16'hFFFF, 8'h10, 17);
    repeat (5) @(negedge clk);
    check("mid_addr_thread5", {24'd0, mem_read_address}, 32'h15);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", {31'd0, mem_read_valid}, 32'd0);
    check("async_rst_done", {31'd0, lsu_done}, 32'd0);
    for (int i = 0; i < T; i++) check("async_rst_lsu_out", {24'd0, lsu_out[i]}, 32'd0);
    exp_q.delete();
    done_q.delete();
    for (int i = 0; i < T; i++) exp_lsu[i] = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    warp_state = WARP_IDLE;
    @(negedge clk);

    // Single-thread load after reset
    rs1[1] = 8'h01;
    push_req(1'b0, 8'h01, 8'h00);
    exp_lsu[1] = 8'h03;
    start_op(1'b1, 1'b0, 16'h0002, 8'h00, 2);
    finish_op();

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
